// File: rtl/toggle_gen_pkg.sv
// rtl/toggle_gen_pkg.sv - shared defaults, FSM encoding and mode constants for toggle_pattern_gen
package toggle_gen_pkg;

    localparam int H_DEFAULT  = 8;
    localparam int PW_DEFAULT = 8;
    localparam int CW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam logic SEQ_MODE = 1'b0;
    localparam logic PAR_MODE = 1'b1;

endpackage

// File: rtl/toggle_channel.sv
// rtl/toggle_channel.sv - one toggle channel: P/N config, period timer, remaining counter, out bit
//   clock, reset            clock and synchronous active-high reset
//   cfg_wr                  write cfg_period/cfg_count into this channel's config
//   cfg_period, cfg_count   P and N
//   load                    latch timer=P, remaining=N (run start)
//   en                      channel is allowed to count this cycle
//   out_bit                 this channel's output bit
//   nonzero                 configured N is nonzero
//   finished                remaining is zero
//   last_toggle             the final toggle of this channel happens at the coming edge
module toggle_channel #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [PW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_count,
    input  logic          load,
    input  logic          en,
    output logic          out_bit,
    output logic          nonzero,
    output logic          finished,
    output logic          last_toggle
);

    logic [PW-1:0] period;
    logic [CW-1:0] count;
    logic [PW-1:0] timer;
    logic [CW-1:0] remaining;
    logic [PW-1:0] period_eff;
    logic          toggle_now;

    // A programmed period of 0 behaves like 1 so the timer can never sit at zero.
    assign period_eff  = (period == '0) ? PW'(1) : period;
    assign toggle_now  = en && (remaining != '0) && (timer <= PW'(1));
    assign last_toggle = toggle_now && (remaining == CW'(1));
    assign finished    = (remaining == '0);
    assign nonzero     = (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            period    <= PW'(1);
            count     <= '0;
            timer     <= PW'(1);
            remaining <= '0;
            out_bit   <= 1'b0;
        end else begin
            if (cfg_wr) begin
                period <= cfg_period;
                count  <= cfg_count;
            end
            if (load) begin
                timer     <= period_eff;
                remaining <= count;
            end else if (en && (remaining != '0)) begin
                if (toggle_now) begin
                    out_bit   <= ~out_bit;
                    remaining <= remaining - CW'(1);
                    timer     <= period_eff;
                end else begin
                    timer <= timer - PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/toggle_pattern_gen.sv
// rtl/toggle_pattern_gen.sv - programmable per-channel toggle generator for detector self-test
//   clock, reset            clock and synchronous active-high reset
//   cfg_we, cfg_ch          config write strobe and channel index (ignored while busy)
//   cfg_period, cfg_count   per-channel P (0 acts as 1) and N (0 disables)
//   mode                    0 sequential, 1 parallel; sampled at start
//   start, stop             begin / abort a run
//   out                     toggle pattern, one bit per channel
//   busy, done              run in progress / one-cycle normal completion pulse
//   active_ch               running channel in sequential mode, else 0
module toggle_pattern_gen
    import toggle_gen_pkg::*;
#(
    parameter int H  = H_DEFAULT,
    parameter int PW = PW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [$clog2(H)-1:0] cfg_ch,
    input  logic [PW-1:0]        cfg_period,
    input  logic [CW-1:0]        cfg_count,
    input  logic                 mode,
    input  logic                 start,
    input  logic                 stop,
    output logic [H-1:0]         out,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(H)-1:0] active_ch
);

    localparam int AW = $clog2(H);

    state_t        state, state_n;
    logic [AW-1:0] cur, cur_n;
    logic          done_n;
    logic          load;
    logic [H-1:0]  en;
    logic [H-1:0]  cfg_wr;
    logic [H-1:0]  nonzero;
    logic [H-1:0]  finished;
    logic [H-1:0]  last;
    logic          first_found, next_found;
    logic [AW-1:0] first_idx, next_idx;

    for (genvar i = 0; i < H; i++) begin : g_ch
        assign cfg_wr[i] = cfg_we && (state == IDLE) && (cfg_ch == AW'(i));

        toggle_channel #(
            .PW (PW),
            .CW (CW)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .cfg_wr      (cfg_wr[i]),
            .cfg_period  (cfg_period),
            .cfg_count   (cfg_count),
            .load        (load),
            .en          (en[i]),
            .out_bit     (out[i]),
            .nonzero     (nonzero[i]),
            .finished    (finished[i]),
            .last_toggle (last[i])
        );
    end

    // Priority search, lowest index wins: first enabled channel overall, and
    // first enabled channel above the one currently running.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = H - 1; i >= 0; i--) begin
            if (nonzero[i]) begin
                first_found = 1'b1;
                first_idx   = AW'(i);
            end
            if (nonzero[i] && (AW'(i) > cur)) begin
                next_found = 1'b1;
                next_idx   = AW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cur   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            done  <= done_n;
        end
    end

    // Channels keep counting on the edge that samples stop, so a final toggle
    // coinciding with stop still lands; only the done pulse is withheld.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        done_n  = 1'b0;
        load    = 1'b0;
        en      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (first_found) begin
                        cur_n   = first_idx;
                        state_n = (mode == PAR_MODE) ? PAR : SEQ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SEQ: begin
                en[cur] = 1'b1;
                if (last[cur]) begin
                    if (next_found) begin
                        cur_n = next_idx;
                    end else begin
                        state_n = IDLE;
                        done_n  = ~stop;
                    end
                end
                if (stop) begin
                    state_n = IDLE;
                end
            end
            PAR: begin
                en = '1;
                if (&(finished | last)) begin
                    state_n = IDLE;
                    done_n  = ~stop;
                end
                if (stop) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign active_ch = (state == SEQ) ? cur : '0;

endmodule

// File: tb/tb_toggle_pattern_gen.sv
// tb/tb_toggle_pattern_gen.sv - scoreboard testbench for toggle_pattern_gen
module tb_toggle_pattern_gen;

    typedef struct {
        int         t;
        logic [7:0] v;
    } ev_t;

    logic       clock;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_period;
    logic [7:0] cfg_count;
    logic       mode;
    logic       start;
    logic       stop;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic [2:0] active_ch;

    int         tests_run;
    int         tests_failed;
    ev_t        sb[$];
    logic [7:0] m_p [0:7];
    logic [7:0] m_n [0:7];
    logic [7:0] model_out;
    int         exp_act [0:1023];

    toggle_pattern_gen dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .out        (dout),
        .busy       (busy),
        .done       (done),
        .active_ch  (active_ch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        model_out = 8'h00;
        for (int c = 0; c < 8; c++) begin
            m_p[c] = 8'd1;
            m_n[c] = 8'd0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_cfg(input int ch, input int p, input int n);
        cfg_we     = 1'b1;
        cfg_ch     = 3'(ch);
        cfg_period = 8'(p);
        cfg_count  = 8'(n);
        @(posedge clock);
        @(negedge clock);
        cfg_we     = 1'b0;
        m_p[ch]    = 8'(p);
        m_n[ch]    = 8'(n);
    endtask

    // Reference model: expected toggle edges (offsets from start edge k) into the scoreboard.
    task automatic build_model(input logic md, input int stop_edge,
                               output int t_end, output int lim, output logic stopped);
        logic [7:0] flip [0:1023];
        logic [7:0] o;
        int         base, pe, fin;
        ev_t        e;
        for (int i = 0; i < 1024; i++) begin
            flip[i]    = 8'h00;
            exp_act[i] = 0;
        end
        t_end = 0;
        base  = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_n[c] != 8'd0) begin
                pe = (m_p[c] == 8'd0) ? 1 : int'(m_p[c]);
                if (md) base = 0;
                fin = base + pe * int'(m_n[c]);
                for (int j = 1; j <= int'(m_n[c]); j++)
                    flip[base + j * pe] = flip[base + j * pe] ^ (8'h01 << c);
                if (!md) begin
                    for (int m = base; m < fin; m++) exp_act[m] = c;
                    base = fin;
                end
                if (fin > t_end) t_end = fin;
            end
        end
        stopped = (stop_edge > 0) && (stop_edge <= t_end);
        lim     = stopped ? stop_edge : t_end;
        sb.delete();
        o = model_out;
        for (int m = 1; m <= lim; m++) begin
            if (flip[m] != 8'h00) begin
                o   = o ^ flip[m];
                e.t = m;
                e.v = o;
                sb.push_back(e);
            end
        end
        model_out = o;
    endtask

    task automatic run_check(input string name, input logic md, input int stop_edge,
                             input int pulse_edge, input logic stop_at_start);
        int         t_end, lim;
        logic       stopped;
        logic [7:0] prev;
        ev_t        e;
        logic       exp_busy, exp_done;
        logic [2:0] exp_ac;
        prev = model_out;
        build_model(md, stop_edge, t_end, lim, stopped);
        for (int m = 0; m <= lim + 2; m++) begin
            if (m == 0) begin
                mode  = md;
                start = 1'b1;
                stop  = stop_at_start;
            end else begin
                stop = (m == stop_edge);
                if (m == pulse_edge) begin
                    cfg_we     = 1'b1;
                    cfg_ch     = 3'd0;
                    cfg_period = 8'd1;
                    cfg_count  = 8'd7;
                    start      = 1'b1;
                    mode       = ~md;
                end
            end
            @(posedge clock);
            @(negedge clock);
            start  = 1'b0;
            stop   = 1'b0;
            cfg_we = 1'b0;
            if (dout !== prev) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s unexpected toggle: t=%0d out=%h, required no change from %h", name, m, dout, prev);
                end else begin
                    e = sb.pop_front();
                    if (e.t !== m || e.v !== dout) begin
                        tests_failed++;
                        $display("FAIL %s toggle: t=%0d out=%h, required t=%0d out=%h", name, m, dout, e.t, e.v);
                    end
                end
                prev = dout;
            end
            exp_busy = (m < lim);
            exp_done = !stopped && (m == t_end);
            exp_ac   = (!md && m < lim) ? 3'(exp_act[m]) : 3'd0;
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s busy: t=%0d got %b, required %b", name, m, busy, exp_busy);
            end
            tests_run++;
            if (done !== exp_done) begin
                tests_failed++;
                $display("FAIL %s done: t=%0d got %b, required %b", name, m, done, exp_done);
            end
            tests_run++;
            if (active_ch !== exp_ac) begin
                tests_failed++;
                $display("FAIL %s active_ch: t=%0d got %0d, required %0d", name, m, active_ch, exp_ac);
            end
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s missing toggles: %0d left, next required t=%0d out=%h", name, sb.size(), sb[0].t, sb[0].v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || active_ch !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset: out=%h busy=%b done=%b active_ch=%0d, required 00 0 0 0", dout, busy, done, active_ch);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_seq_single();
        write_cfg(0, 3, 10);
        run_check("seq_single", 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_seq_two();
        write_cfg(0, 3, 2);
        write_cfg(1, 1, 3);
        run_check("seq_two", 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_par();
        do_reset();
        write_cfg(0, 2, 4);
        write_cfg(1, 3, 2);
        run_check("par", 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_busy_ignore_and_stop();
        write_cfg(0, 3, 2);
        write_cfg(1, 1, 3);
        run_check("busy_ignore", 1'b0, -1, 2, 1'b0);
        run_check("stop_mid", 1'b0, 5, -1, 1'b0);
        run_check("stop_last", 1'b0, 9, -1, 1'b0);
    endtask

    task automatic test_p_zero();
        write_cfg(0, 3, 0);
        write_cfg(1, 1, 0);
        write_cfg(2, 0, 2);
        run_check("p_zero", 1'b0, -1, -1, 1'b0);
        run_check("start_wins", 1'b1, -1, -1, 1'b1);
    endtask

    task automatic test_all_zero(input string name);
        for (int c = 0; c < 8; c++) begin
            if (m_n[c] != 8'd0) write_cfg(c, int'(m_p[c]), 0);
        end
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s pulse: done=%b busy=%b, required 1 0", name, done, busy);
        end
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || dout !== model_out) begin
            tests_failed++;
            $display("FAIL %s after: done=%b busy=%b out=%h, required 0 0 %h", name, done, busy, dout, model_out);
        end
    endtask

    task automatic test_reset_mid_run();
        write_cfg(0, 2, 4);
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        tests_run++;
        if (busy !== 1'b1 || dout[0] !== ~model_out[0]) begin
            tests_failed++;
            $display("FAIL reset_mid pre: busy=%b out=%h, required busy 1 bit0 %b", busy, dout, ~model_out[0]);
        end
        do_reset();
        tests_run++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || active_ch !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: out=%h busy=%b done=%b active_ch=%0d, required 00 0 0 0", dout, busy, done, active_ch);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_ch       = 3'd0;
        cfg_period   = 8'd0;
        cfg_count    = 8'd0;
        mode         = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        model_reset();
        test_reset();
        test_seq_single();
        test_seq_two();
        test_par();
        test_busy_ignore_and_stop();
        test_p_zero();
        test_all_zero("all_zero");
        test_reset_mid_run();
        test_all_zero("all_zero_after_reset");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
